// File: rtl/candy_dispense_sequencer_if.sv
// Handshake bundle between the debounced coin/button inputs, the vending
// sequencer and the LED/7-segment display logic.
interface candy_dispense_sequencer_if;
   logic       coin_valid;
   logic [1:0] coin_value;
   logic       select;
   logic       cancel;
   logic [7:0] credit;
   logic       dispense;
   logic       blink;
   logic       change_valid;
   logic [7:0] change_amt;
   logic       coin_reject;
   logic [2:0] state;

   modport master (
      output coin_valid, coin_value, select, cancel,
      input  credit, dispense, blink, change_valid, change_amt, coin_reject, state
   );

   modport slave (
      input  coin_valid, coin_value, select, cancel,
      output credit, dispense, blink, change_valid, change_amt, coin_reject, state
   );
endinterface

// File: rtl/candy_dispense_sequencer.sv
// Candy machine vending controller: coin credit accumulation, selection,
// and timed dispense/change/refund phases driven by a half-second tick enable.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | no credit, waiting for the first coin
// CREDIT   | accumulating coins, waiting for select/cancel/timeout
// DISPENSE | dispense motor on for DISPENSE_TICKS ticks, blink toggles
// CHANGE   | paying out remainder after a purchase
// REFUND   | returning all credit after cancel or timeout
module candy_dispense_sequencer #(
   parameter int TICK_DIV       = 50_000_000,
   parameter int PRICE          = 75,
   parameter int DISPENSE_TICKS = 4,
   parameter int CHANGE_TICKS   = 2,
   parameter int TIMEOUT_TICKS  = 20
) (
   input logic                          clk_100MHz,
   input logic                          reset,
   candy_dispense_sequencer_if.slave    bus
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CREDIT   = 3'd1,
      ST_DISPENSE = 3'd2,
      ST_CHANGE   = 3'd3,
      ST_REFUND   = 3'd4
   } state_t;

   localparam int PRESC_W = $clog2(TICK_DIV);
   localparam int MAX_T1  = (DISPENSE_TICKS > CHANGE_TICKS) ? DISPENSE_TICKS : CHANGE_TICKS;
   localparam int MAX_T   = (MAX_T1 > TIMEOUT_TICKS) ? MAX_T1 : TIMEOUT_TICKS;
   localparam int TCW     = $clog2(MAX_T + 1);

   state_t             state_q, state_d;
   logic [PRESC_W-1:0] presc_q;
   logic [TCW-1:0]     tick_cnt_q;
   logic [7:0]         credit_q, credit_d;
   logic               blink_q, blink_d;
   logic               chg_valid_q, chg_valid_d;
   logic [7:0]         chg_amt_q, chg_amt_d;
   logic               reject_q, reject_d;
   logic               coin_taken;
   logic               clr_timer;
   logic               tick, pre_tick;
   logic [8:0]         coin_amt;
   logic [8:0]         sum;
   logic               coin_ok;

   assign tick     = (presc_q == PRESC_W'(TICK_DIV - 1));
   assign pre_tick = (presc_q == PRESC_W'(TICK_DIV - 2));

   always_comb begin
      coin_amt = 9'd0;
      case (bus.coin_value)
         2'b00:   coin_amt = 9'd5;
         2'b01:   coin_amt = 9'd10;
         2'b10:   coin_amt = 9'd25;
         default: coin_amt = 9'd0;
      endcase
   end

   assign sum     = {1'b0, credit_q} + coin_amt;
   assign coin_ok = bus.coin_valid && (bus.coin_value != 2'b11) && !sum[8];

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         credit_q    <= '0;
         blink_q     <= 1'b0;
         chg_valid_q <= 1'b0;
         chg_amt_q   <= '0;
         reject_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         credit_q    <= credit_d;
         blink_q     <= blink_d;
         chg_valid_q <= chg_valid_d;
         chg_amt_q   <= chg_amt_d;
         reject_q    <= reject_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      credit_d    = credit_q;
      blink_d     = 1'b0;
      chg_valid_d = 1'b0;
      chg_amt_d   = '0;
      reject_d    = 1'b0;
      coin_taken  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.cancel) begin
               reject_d = bus.coin_valid;
            end else if (bus.coin_valid) begin
               if (coin_ok) begin
                  credit_d   = sum[7:0];
                  state_d    = ST_CREDIT;
                  coin_taken = 1'b1;
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         ST_CREDIT: begin
            if (bus.cancel) begin
               reject_d = bus.coin_valid;
               state_d  = ST_REFUND;
            end else begin
               if (bus.coin_valid) begin
                  if (coin_ok) begin
                     credit_d   = sum[7:0];
                     coin_taken = 1'b1;
                  end else begin
                     reject_d = 1'b1;
                  end
               end else if (bus.select && (credit_q >= 8'(PRICE))) begin
                  credit_d = credit_q - 8'(PRICE);
                  state_d  = ST_DISPENSE;
               end
               // A rejected coin does not restart the timeout window.
               if (!coin_taken && (state_d == ST_CREDIT) && tick &&
                   (tick_cnt_q == TCW'(TIMEOUT_TICKS - 1)))
                  state_d = ST_REFUND;
            end
         end
         ST_DISPENSE: begin
            reject_d = bus.coin_valid;
            blink_d  = blink_q ^ tick;
            if (tick && (tick_cnt_q == TCW'(DISPENSE_TICKS - 1))) begin
               blink_d = 1'b0;
               state_d = (credit_q != 8'd0) ? ST_CHANGE : ST_IDLE;
            end
         end
         ST_CHANGE, ST_REFUND: begin
            reject_d = bus.coin_valid;
            // Strobe is registered one cycle early so it lands on the final tick cycle.
            if (pre_tick && (tick_cnt_q == TCW'(CHANGE_TICKS - 1))) begin
               chg_valid_d = 1'b1;
               chg_amt_d   = credit_q;
            end
            if (tick && (tick_cnt_q == TCW'(CHANGE_TICKS - 1))) begin
               credit_d = '0;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            credit_d = '0;
         end
      endcase
   end

   assign clr_timer = coin_taken || (state_d != state_q);

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         presc_q    <= '0;
         tick_cnt_q <= '0;
      end else if (clr_timer) begin
         presc_q    <= '0;
         tick_cnt_q <= '0;
      end else if (tick) begin
         presc_q    <= '0;
         tick_cnt_q <= tick_cnt_q + 1'b1;
      end else begin
         presc_q    <= presc_q + 1'b1;
      end
   end

   assign bus.credit       = credit_q;
   assign bus.dispense     = (state_q == ST_DISPENSE);
   assign bus.blink        = blink_q;
   assign bus.change_valid = chg_valid_q;
   assign bus.change_amt   = chg_amt_q;
   assign bus.coin_reject  = reject_q;
   assign bus.state        = state_q;

endmodule

// File: tb/tb_candy_dispense_sequencer.sv
// Scoreboard bench for the candy vending sequencer: expected payouts are
// queued when a scenario is driven and matched against change_valid strobes.
module tb_candy_dispense_sequencer;
   localparam int TICK_DIV       = 4;
   localparam int PRICE          = 75;
   localparam int DISPENSE_TICKS = 4;
   localparam int CHANGE_TICKS   = 2;
   localparam int TIMEOUT_TICKS  = 5;

   localparam logic [2:0] S_IDLE = 3'd0, S_CREDIT = 3'd1, S_DISP = 3'd2,
                          S_CHANGE = 3'd3, S_REFUND = 3'd4;
   localparam logic [1:0] C5 = 2'b00, C10 = 2'b01, C25 = 2'b10, CBAD = 2'b11;

   logic clk_100MHz;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   exp_q[$];
   logic prev_cv  = 1'b0;

   candy_dispense_sequencer_if bus ();

   candy_dispense_sequencer #(
      .TICK_DIV(TICK_DIV), .PRICE(PRICE), .DISPENSE_TICKS(DISPENSE_TICKS),
      .CHANGE_TICKS(CHANGE_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS)
   ) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .bus        (bus.slave)
   );

   initial clk_100MHz = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic coin(input logic [1:0] v);
      bus.coin_valid = 1'b1;
      bus.coin_value = v;
      step();
      bus.coin_valid = 1'b0;
      bus.coin_value = 2'b00;
   endtask

   task automatic pulse_select();
      bus.select = 1'b1;
      step();
      bus.select = 1'b0;
   endtask

   task automatic pulse_cancel();
      bus.cancel = 1'b1;
      step();
      bus.cancel = 1'b0;
   endtask

   // Counts cycles until the state leaves s; a blown budget is reported as a failure.
   task automatic wait_leave(input logic [2:0] s, output int n);
      n = 0;
      while (bus.state == s && n < 500) begin
         step();
         n++;
      end
      if (n >= 500) chk("wait_budget", 32'(n), 32'd0);
   endtask

   // Scoreboard side: every payout strobe must match the oldest queued amount.
   always @(negedge clk_100MHz) begin
      if (!reset && bus.change_valid) begin
         chk("cv_in_payout_state", 32'(bus.state == S_CHANGE || bus.state == S_REFUND), 32'd1);
         chk("cv_width", 32'(prev_cv), 32'd0);
         if (exp_q.size() > 0) chk("cv_amt", 32'(bus.change_amt), 32'(exp_q.pop_front()));
         else                  chk("cv_unexpected", 32'(exp_q.size()), 32'd1);
      end
      if (!reset && !bus.change_valid)
         if (bus.change_amt != 8'd0) chk("cv_amt_idle", 32'(bus.change_amt), 32'd0);
      prev_cv = bus.change_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int toggles;
      logic pb;

      reset          = 1'b1;
      bus.coin_valid = 1'b0;
      bus.coin_value = 2'b00;
      bus.select     = 1'b0;
      bus.cancel     = 1'b0;
      step(); step();
      chk("rst_state",    32'(bus.state),        32'(S_IDLE));
      chk("rst_credit",   32'(bus.credit),       32'd0);
      chk("rst_dispense", 32'(bus.dispense),     32'd0);
      chk("rst_cv",       32'(bus.change_valid), 32'd0);
      chk("rst_reject",   32'(bus.coin_reject),  32'd0);
      reset = 1'b0;
      step();

      // Exact payment: no change afterwards.
      coin(C25);
      chk("exact_first_state", 32'(bus.state), 32'(S_CREDIT));
      coin(C25); coin(C25);
      chk("exact_credit", 32'(bus.credit), 32'd75);
      pulse_select();
      chk("exact_disp_rise", 32'(bus.dispense), 32'd1);
      chk("exact_credit0", 32'(bus.credit), 32'd0);
      chk("exact_blink0", 32'(bus.blink), 32'd0);
      n = 0; toggles = 0; pb = bus.blink;
      while (bus.dispense && n < 100) begin
         n++;
         step();
         if (bus.blink != pb) toggles++;
         pb = bus.blink;
      end
      chk("exact_disp_len", 32'(n), 32'(DISPENSE_TICKS * TICK_DIV));
      chk("exact_blink_toggles", 32'(toggles), 32'(DISPENSE_TICKS));
      chk("exact_idle", 32'(bus.state), 32'(S_IDLE));
      repeat (4) step();

      // Overpay: 100 cents, 25 back.
      repeat (4) coin(C25);
      chk("over_credit", 32'(bus.credit), 32'd100);
      exp_q.push_back(25);
      pulse_select();
      chk("over_credit_after_sel", 32'(bus.credit), 32'd25);
      wait_leave(S_DISP, n);
      chk("over_disp_len", 32'(n), 32'(DISPENSE_TICKS * TICK_DIV));
      chk("over_change_state", 32'(bus.state), 32'(S_CHANGE));
      wait_leave(S_CHANGE, n);
      chk("over_change_len", 32'(n), 32'(CHANGE_TICKS * TICK_DIV));
      chk("over_idle", 32'(bus.state), 32'(S_IDLE));
      chk("over_credit_clr", 32'(bus.credit), 32'd0);

      // Underpay, ignored select, then timeout refund of 35.
      coin(C25); coin(C10);
      chk("under_credit", 32'(bus.credit), 32'd35);
      exp_q.push_back(35);
      pulse_select();
      chk("under_sel_ignored", 32'(bus.state), 32'(S_CREDIT));
      chk("under_sel_credit", 32'(bus.credit), 32'd35);
      wait_leave(S_CREDIT, n);
      // One of the timeout cycles was already spent on the select pulse.
      chk("under_timeout_len", 32'(n), 32'(TIMEOUT_TICKS * TICK_DIV - 1));
      chk("under_refund_state", 32'(bus.state), 32'(S_REFUND));
      wait_leave(S_REFUND, n);
      chk("under_refund_len", 32'(n), 32'(CHANGE_TICKS * TICK_DIV));
      chk("under_credit_clr", 32'(bus.credit), 32'd0);

      // cancel beats a coin in the same cycle.
      coin(C25); coin(C25);
      exp_q.push_back(50);
      bus.cancel = 1'b1; bus.coin_valid = 1'b1; bus.coin_value = C10;
      step();
      bus.cancel = 1'b0; bus.coin_valid = 1'b0; bus.coin_value = 2'b00;
      chk("cc_reject", 32'(bus.coin_reject), 32'd1);
      chk("cc_state", 32'(bus.state), 32'(S_REFUND));
      chk("cc_credit", 32'(bus.credit), 32'd50);
      step();
      chk("cc_reject_width", 32'(bus.coin_reject), 32'd0);
      wait_leave(S_REFUND, n);
      chk("cc_idle", 32'(bus.state), 32'(S_IDLE));

      // Coin arriving during DISPENSE is refused.
      repeat (3) coin(C25);
      pulse_select();
      step();
      coin(C10);
      chk("disp_coin_reject", 32'(bus.coin_reject), 32'd1);
      chk("disp_coin_credit", 32'(bus.credit), 32'd0);
      chk("disp_coin_state", 32'(bus.state), 32'(S_DISP));
      wait_leave(S_DISP, n);
      chk("disp_coin_idle", 32'(bus.state), 32'(S_IDLE));

      // Saturation near 255 and the reserved coin code.
      repeat (10) coin(C25);
      chk("sat_credit250", 32'(bus.credit), 32'd250);
      coin(C10);
      chk("sat_reject", 32'(bus.coin_reject), 32'd1);
      chk("sat_credit_hold", 32'(bus.credit), 32'd250);
      coin(CBAD);
      chk("bad_reject", 32'(bus.coin_reject), 32'd1);
      chk("bad_credit_hold", 32'(bus.credit), 32'd250);
      coin(C5);
      chk("sat_fill255", 32'(bus.credit), 32'd255);
      chk("sat_fill_no_reject", 32'(bus.coin_reject), 32'd0);
      exp_q.push_back(255);
      pulse_cancel();
      chk("sat_cancel_state", 32'(bus.state), 32'(S_REFUND));
      wait_leave(S_REFUND, n);
      chk("sat_idle", 32'(bus.state), 32'(S_IDLE));

      // Reset five cycles into DISPENSE drops credit with no payout.
      repeat (4) coin(C25);
      pulse_select();
      repeat (4) step();
      chk("rstmid_in_disp", 32'(bus.dispense), 32'd1);
      reset = 1'b1;
      #1;
      chk("rstmid_dispense", 32'(bus.dispense), 32'd0);
      chk("rstmid_credit", 32'(bus.credit), 32'd0);
      chk("rstmid_state", 32'(bus.state), 32'(S_IDLE));
      step(); step();
      reset = 1'b0;
      repeat (40) step();
      chk("rstmid_stays_idle", 32'(bus.state), 32'(S_IDLE));

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/candy_dispense_sequencer.md
# candy_dispense_sequencer

Vending controller for the Basys3 candy machine. It accepts coin pulses, accumulates credit and accepts a product selection once credit covers the price. It then sequences the dispense, change and refund phases using an internal half-second tick prescaler. The prescaler is a clock-enable, not a derived clock, and restarts on every state entry so each phase lasts exactly N ticks. The block sits between the debounced button/coin inputs and the LED/7-segment display logic.

## Interface
- TICK_DIV, 50_000_000: clk cycles per tick (0.5 s at 100 MHz); must be ≥2.
- PRICE, 75: product price in cents, 1..255.
- DISPENSE_TICKS, 4: ticks `dispense` stays high.
- CHANGE_TICKS, 2: ticks spent in CHANGE/REFUND before payout.
- TIMEOUT_TICKS, 20: idle ticks in CREDIT before auto-refund.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- coin_valid  in  1  one-cycle coin strobe.
- coin_value  in  2  00=5, 01=10, 10=25, 11=reserved (rejected).
- select  in  1  one-cycle purchase strobe.
- cancel  in  1  one-cycle refund strobe.
- credit  out  8  current credit in cents.
- dispense  out  1  high during DISPENSE.
- blink  out  1  toggles each tick in DISPENSE, 0 elsewhere.
- change_valid  out  1  one-cycle payout strobe.
- change_amt  out  8  payout amount, valid with change_valid, else 0.
- coin_reject  out  1  one-cycle strobe for a refused coin.
- state  out  3  IDLE=0, CREDIT=1, DISPENSE=2, CHANGE=3, REFUND=4.

## Operation
- Prescaler counts 0..TICK_DIV-1; tick is a one-cycle pulse on the cycle the count equals TICK_DIV-1.
- The prescaler and tick counter clear on every state transition and on every accepted coin.
- Input priority in IDLE/CREDIT is cancel > coin > select. Lower-priority inputs in the same cycle are ignored, and a coin ignored this way pulses coin_reject.
- IDLE:
  - A valid coin loads credit = value and moves to CREDIT.
  - cancel and select are ignored.
- CREDIT:
  - A valid coin adds its value.
  - select with credit ≥ PRICE subtracts PRICE and moves to DISPENSE. select with credit < PRICE is ignored.
  - cancel moves to REFUND.
  - TIMEOUT_TICKS ticks without an accepted coin moves to REFUND.
- DISPENSE: dispense=1. After DISPENSE_TICKS ticks, go to CHANGE if credit > 0, otherwise go to IDLE.
- CHANGE/REFUND: wait CHANGE_TICKS ticks. On the final tick cycle, pulse change_valid with change_amt = credit, clear credit and go to IDLE.
- Coin rejection: a coin is rejected (coin_reject pulse, credit unchanged) if:
  - it arrives in DISPENSE, CHANGE or REFUND,
  - coin_value = 11, or
  - credit + value > 255.
- Arithmetic: 9-bit sum for the overflow check; credit never wraps.

## Timing
- Reset values: state=IDLE, credit=0, prescaler=0, and all other outputs 0. Reset mid-phase aborts immediately; credit is lost and no payout is made.
- All outputs are registered. credit updates the cycle after an accepted coin or select.
- dispense rises the cycle after an accepted select and is high for exactly DISPENSE_TICKS×TICK_DIV cycles.
- change_valid occurs CHANGE_TICKS×TICK_DIV cycles after entering CHANGE/REFUND. state reads IDLE on the following cycle.
- Timeout fires exactly TIMEOUT_TICKS×TICK_DIV cycles after the last accepted coin (or after entry to CREDIT).
- blink starts at 0 on DISPENSE entry and first toggles on the first tick.
- coin_reject and change_valid are never high for more than one cycle per event.

## Test plan
(All scenarios use TICK_DIV=4, PRICE=75, DISPENSE_TICKS=4, CHANGE_TICKS=2, TIMEOUT_TICKS=5.)
- Exact payment: coins 25, 25, 25, then select. Expect credit 75→0, dispense high for 16 cycles, blink toggling 4 times, then IDLE with no change_valid.
- Overpay: coins 25×4 (100), then select. Expect dispense for 16 cycles, then CHANGE for 8 cycles, change_valid with change_amt=25, credit=0.
- Underpay and timeout: coins 25 and 10 (35). select is ignored. After 20 cycles with no coin, REFUND runs, then change_valid with change_amt=35.
- Simultaneous inputs: cancel+coin in the same cycle at credit 50 gives coin_reject and REFUND, then change_amt=50. A coin during DISPENSE gives coin_reject with credit unchanged.
- Saturation and bad coin: drive credit to 250, then coin 10 → coin_reject, credit stays 250. coin_value=11 → coin_reject.
- Reset mid-dispense: assert reset 5 cycles into DISPENSE. dispense=0 and credit=0 immediately, state=IDLE, and no change_valid ever follows.
